// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient and remainder.
// One quotient bit per clock. Divide-by-zero and overflow resolve in one edge.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] part_next;

  // The partial remainder starts as the dividend high half; shreg feeds the low half in
  // MSB-first and collects quotient bits at its bottom.
  always_comb begin
    shifted   = {part_q, shreg_q[WIDTH-1]};
    ge        = (shifted >= {1'b0, divisor_q});
    part_next = ge ? (shifted[WIDTH-1:0] - divisor_q) : shifted[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    part_d      = part_q;
    shreg_d     = shreg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          divisor_d = divisor;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          // Zero divisor is tested first: it would also pass the overflow compare.
          if (divisor == '0) begin
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[WIDTH-1:0];
            state_d     = S_DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            ovf_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
            state_d     = S_DONE;
          end else begin
            part_d  = dividend[2*WIDTH-1:WIDTH];
            shreg_d = dividend[WIDTH-1:0];
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        part_d  = part_next;
        shreg_d = {shreg_q[WIDTH-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quotient_d  = {shreg_q[WIDTH-2:0], ge};
          remainder_d = part_next;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      divisor_q   <= '0;
      part_q      <= '0;
      shreg_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      part_q      <= part_d;
      shreg_q     <= shreg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(dbz_q && ovf_q));
  a_busy_done_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule
